// File: rtl/ssg_capture.sv
// ssg_capture: passive reader that rebuilds hex digits from muxed 7-seg lines.
// Optional SSG_CAPTURE_LAST_PATTERN_EN adds last_pattern/last_index outputs.
module ssg_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   ssg_anode_in,
  input  logic [6:0]              ssg_cathode_in,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] digit_values,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    anode_conflict
`ifdef SSG_CAPTURE_LAST_PATTERN_EN
  ,
  output logic [6:0]              last_pattern,
  output logic [2:0]              last_index
`endif
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_e;

  state_e                  state_q;
  logic [NUM_DIGITS-1:0]   s_an_q;
  logic [NUM_DIGITS-1:0]   prv_an_q;
  logic [6:0]              s_cc_q;
  logic [6:0]              prv_cc_q;
  logic [7:0]              cnt_q;
  logic [7:0]              cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q;
  logic [NUM_DIGITS-1:0]   seen_d;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    frame_q;
  logic                    perr_q;
  logic                    conf_q;

  logic [3:0]    nz;
  logic          one;
  logic          multi;
  logic          same;
  logic          commit;
  logic [IW-1:0] idx;
  logic [4:0]    dec;
  logic          is_blank;
  logic          illegal;

  always_comb begin
    nz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nz = nz + {3'b000, ~s_an_q[i]};
    end
  end

  assign one   = (nz == 4'd1);
  assign multi = (nz > 4'd1);
  assign same  = (s_an_q == prv_an_q) && (s_cc_q == prv_cc_q);

  // prv_* holds the last counted sample, so it is what gets committed
  assign commit = (state_q == TRACK) && (cnt_q == STABLE);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!prv_an_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    dec = 5'h00;
    unique case (prv_cc_q)
      7'b0000001: dec = 5'h10;
      7'b1001111: dec = 5'h11;
      7'b0010010: dec = 5'h12;
      7'b0000110: dec = 5'h13;
      7'b1001100: dec = 5'h14;
      7'b0100100: dec = 5'h15;
      7'b0100000: dec = 5'h16;
      7'b0001111: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0000100: dec = 5'h19;
      7'b0001000: dec = 5'h1A;
      7'b1100000: dec = 5'h1B;
      7'b0110001: dec = 5'h1C;
      7'b1000010: dec = 5'h1D;
      7'b0110000: dec = 5'h1E;
      7'b0111000: dec = 5'h1F;
      default:    dec = 5'h00;
    endcase
  end

  assign is_blank = (prv_cc_q == BLANK);
  assign illegal  = !dec[4] && !is_blank;

  always_comb begin
    cnt_d = 8'd0;
    if (one) begin
      if (!same) cnt_d = 8'd1;
      else if (cnt_q == STABLE) cnt_d = cnt_q;
      else cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    seen_d = seen_q;
    if (commit) seen_d[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_an_q   <= '1;
      prv_an_q <= '1;
      s_cc_q   <= BLANK;
      prv_cc_q <= BLANK;
      cnt_q    <= 8'd0;
      seen_q   <= '0;
      val_q    <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      frame_q  <= 1'b0;
      perr_q   <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      s_an_q   <= ssg_anode_in;
      s_cc_q   <= ssg_cathode_in;
      prv_an_q <= s_an_q;
      prv_cc_q <= s_cc_q;
      cnt_q    <= cnt_d;
      conf_q   <= (conf_q & ~clear_err) | multi;
      perr_q   <= (perr_q & ~clear_err) | (commit & illegal);
      frame_q  <= &seen_d;
      seen_q   <= (&seen_d) ? '0 : seen_d;
      unique case (state_q)
        IDLE: begin
          if (one) state_q <= TRACK;
        end
        TRACK: begin
          if (commit) begin
            if (!one) state_q <= IDLE;
            else if (same) state_q <= LOCKED;
            else state_q <= TRACK;
          end else if (!one) begin
            state_q <= IDLE;
          end
        end
        LOCKED: begin
          if (!one) state_q <= IDLE;
          else if (!same) state_q <= TRACK;
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        valid_q[idx] <= dec[4];
        blank_q[idx] <= is_blank;
        if (dec[4]) val_q[{idx, 2'b00} +: 4] <= dec[3:0];
      end
    end
  end

  assign digit_values   = val_q;
  assign digit_valid    = valid_q;
  assign digit_blank    = blank_q;
  assign frame_done     = frame_q;
  assign pattern_err    = perr_q;
  assign anode_conflict = conf_q;

`ifdef SSG_CAPTURE_LAST_PATTERN_EN
  logic [6:0] lpat_q;
  logic [2:0] lidx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lpat_q <= BLANK;
      lidx_q <= 3'd0;
    end else if (commit) begin
      lpat_q <= prv_cc_q;
      lidx_q <= 3'(idx);
    end
  end

  assign last_pattern = lpat_q;
  assign last_index   = lidx_q;
`endif

endmodule
